// File: rtl/fp_add_serial.sv
// fp_add_serial: digit-serial modular add (and optional subtract) over Fp.
// Processes DIGIT bits per cycle, least-significant digit first, running a
// primary chain and a correction chain (against MODULUS) in parallel, then
// picks the reduced value once the final carries are known.
// Optional feature macro: FPADD_SUB_EN adds the op port and the subtract path.
module fp_add_serial #(
  parameter int unsigned      WIDTH   = 434,
  parameter int unsigned      DIGIT   = 64,
  parameter logic [WIDTH-1:0] MODULUS = 434'h2341F27177344_6CFC5FD681C52056_7BC65C783158AEA3_FDC1767AE2FFFFFF_FFFFFFFFFFFFFFFF_FFFFFFFFFFFFFFFF_FFFFFFFFFFFFFFFF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
`ifdef FPADD_SUB_EN
  input  logic             op,
`endif
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam int unsigned ND = (WIDTH + DIGIT - 1) / DIGIT;
  localparam int unsigned EW = ND * DIGIT;
  localparam int unsigned DW = DIGIT + 1;
  localparam int unsigned CW = (ND > 1) ? $clog2(ND) : 1;
  localparam int unsigned IW = (EW > 1) ? $clog2(EW) : 1;
  localparam logic [EW-1:0] P_EXT = EW'(MODULUS);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;

  state_e           state_q, state_d;
  logic [EW-1:0]    a_q, a_d, b_q, b_d, s_q, s_d, t_q, t_d;
  logic             c_q, c_d, k_q, k_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             busy_q, busy_d, done_q, done_d;
  logic [WIDTH-1:0] result_q, result_d;
`ifdef FPADD_SUB_EN
  logic             op_q, op_d;
`endif

  logic [IW-1:0]    p_idx;
  logic [DIGIT-1:0] p_dig;
  logic [DW-1:0]    pri_sum, cor_sum;
  logic             sel_t;
  logic [EW-1:0]    sel;
  logic             unused_sel_hi;

  // Digit-slice arithmetic: primary chain and correction chain on the current digit
  always_comb begin
    p_idx   = IW'(cnt_q) * IW'(DIGIT);
    p_dig   = P_EXT[p_idx +: DIGIT];
    pri_sum = {1'b0, a_q[DIGIT-1:0]} + {1'b0, b_q[DIGIT-1:0]} + DW'(c_q);
    cor_sum = {1'b0, pri_sum[DIGIT-1:0]} - {1'b0, p_dig} - DW'(k_q);
`ifdef FPADD_SUB_EN
    if (op_q) begin
      pri_sum = {1'b0, a_q[DIGIT-1:0]} - {1'b0, b_q[DIGIT-1:0]} - DW'(c_q);
      cor_sum = {1'b0, pri_sum[DIGIT-1:0]} + {1'b0, p_dig} + DW'(k_q);
    end
`endif
  end

  // Final selection: corrected value when the raw value is out of range
  always_comb begin
    sel_t = c_q | ~k_q;
`ifdef FPADD_SUB_EN
    if (op_q) sel_t = c_q;
`endif
    sel = sel_t ? t_q : s_q;
  end

  // Bits above WIDTH are padding; fold them into a sink
  assign unused_sel_hi = ^(sel >> WIDTH);

  // Next-state and output logic
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    s_d      = s_q;
    t_d      = t_q;
    c_d      = c_q;
    k_d      = k_q;
    cnt_d    = cnt_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    result_d = result_q;
`ifdef FPADD_SUB_EN
    op_d     = op_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_RUN;
          a_d     = EW'(a);
          b_d     = EW'(b);
          s_d     = '0;
          t_d     = '0;
          c_d     = 1'b0;
          k_d     = 1'b0;
          cnt_d   = '0;
          busy_d  = 1'b1;
`ifdef FPADD_SUB_EN
          op_d    = op;
`endif
        end
      end
      S_RUN: begin
        a_d   = a_q >> DIGIT;
        b_d   = b_q >> DIGIT;
        s_d   = (s_q >> DIGIT) | (EW'(pri_sum[DIGIT-1:0]) << (EW - DIGIT));
        t_d   = (t_q >> DIGIT) | (EW'(cor_sum[DIGIT-1:0]) << (EW - DIGIT));
        c_d   = pri_sum[DIGIT];
        k_d   = cor_sum[DIGIT];
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(ND - 1)) state_d = S_DONE;
      end
      S_DONE: begin
        result_d = sel[WIDTH-1:0];
        done_d   = 1'b1;
        busy_d   = 1'b0;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State, datapath and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      s_q      <= '0;
      t_q      <= '0;
      c_q      <= 1'b0;
      k_q      <= 1'b0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
`ifdef FPADD_SUB_EN
      op_q     <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      s_q      <= s_d;
      t_q      <= t_d;
      c_q      <= c_d;
      k_q      <= k_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      result_q <= result_d;
`ifdef FPADD_SUB_EN
      op_q     <= op_d;
`endif
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;

endmodule

// File: tb/tb_fp_add_serial.sv
// Testbench for fp_add_serial with WIDTH=8, DIGIT=4, MODULUS=251 (ND=2).
module tb_fp_add_serial;

  localparam int unsigned W = 8;
  localparam int unsigned P = 251;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic         op_s;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] result;

  int n_tests;
  int n_fail;

  fp_add_serial #(
    .WIDTH  (W),
    .DIGIT  (4),
    .MODULUS(8'd251)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
`ifdef FPADD_SUB_EN
    .op    (op_s),
`endif
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .result(result)
  );

`ifndef FPADD_SUB_EN
  wire unused_op = op_s;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Global time limit
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic launch(input logic [W-1:0] ai, input logic [W-1:0] bi, input logic opi);
    @(negedge clk);
    a     = ai;
    b     = bi;
    op_s  = opi;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Waits (bounded) for done; reports latency and whether busy/result behaved
  task automatic wait_done(input logic [W-1:0] prev, output int lat, output bit busy_ok,
                           output bit stable_ok);
    lat       = 0;
    busy_ok   = 1'b1;
    stable_ok = 1'b1;
    while (!done && lat < 20) begin
      if (!busy) busy_ok = 1'b0;
      if (result !== prev) stable_ok = 1'b0;
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic run_op(input string tag, input logic [W-1:0] ai, input logic [W-1:0] bi,
                        input logic opi, input logic [W-1:0] exp, input bit full);
    int lat;
    bit busy_ok, stable_ok;
    logic [W-1:0] prev;
    prev = result;
    launch(ai, bi, opi);
    wait_done(prev, lat, busy_ok, stable_ok);
    check({tag, " result"}, 32'(result), 32'(exp));
    check({tag, " latency"}, 32'(lat), 32'd3);
    if (full) begin
      check({tag, " busy during op"}, 32'(busy_ok), 32'd1);
      check({tag, " result held"}, 32'(stable_ok), 32'd1);
      check({tag, " busy at done"}, 32'(busy), 32'd0);
    end
    @(posedge clk);
    #1;
    check({tag, " done width"}, 32'(done), 32'd0);
    if (full) check({tag, " result after done"}, 32'(result), 32'(exp));
  endtask

  initial begin
    int lat;
    bit busy_ok, stable_ok, seen;
    n_tests = 0;
    n_fail  = 0;
    rst_n   = 1'b0;
    start   = 1'b0;
    op_s    = 1'b0;
    a       = '0;
    b       = '0;

    // Reset state
    #12;
    check("reset busy", 32'(busy), 32'd0);
    check("reset done", 32'(done), 32'd0);
    check("reset result", 32'(result), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed add cases
    run_op("add 100+50", 8'd100, 8'd50, 1'b0, 8'd150, 1'b1);
    run_op("add 200+100", 8'd200, 8'd100, 1'b0, 8'd49, 1'b1);
    run_op("add 250+1", 8'd250, 8'd1, 1'b0, 8'd0, 1'b1);
    run_op("add 0+0", 8'd0, 8'd0, 1'b0, 8'd0, 1'b1);
    run_op("add 250+250", 8'd250, 8'd250, 1'b0, 8'd249, 1'b1);
    run_op("add 7+243", 8'd7, 8'd243, 1'b0, 8'd250, 1'b1);

`ifdef FPADD_SUB_EN
    run_op("sub 10-20", 8'd10, 8'd20, 1'b1, 8'd241, 1'b1);
    run_op("sub 20-10", 8'd20, 8'd10, 1'b1, 8'd10, 1'b1);
    run_op("sub 77-77", 8'd77, 8'd77, 1'b1, 8'd0, 1'b1);
    run_op("sub 0-250", 8'd0, 8'd250, 1'b1, 8'd1, 1'b1);
`endif

    // start re-pulsed while running must be ignored
    @(negedge clk);
    a     = 8'd100;
    b     = 8'd50;
    op_s  = 1'b0;
    start = 1'b1;
    @(posedge clk);
    #1;
    a = 8'd1;
    b = 8'd1;
    @(posedge clk);
    #1;
    start = 1'b0;
    lat = 1;
    while (!done && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check("ignored start result", 32'(result), 32'd150);
    check("ignored start latency", 32'(lat), 32'd3);
    run_op("after ignored start", 8'd3, 8'd4, 1'b0, 8'd7, 1'b0);

    // Asynchronous reset in the middle of an operation
    launch(8'd120, 8'd30, 1'b0);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("midreset busy", 32'(busy), 32'd0);
    check("midreset done", 32'(done), 32'd0);
    check("midreset result", 32'(result), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (6) begin
      @(posedge clk);
      #1;
      if (done) seen = 1'b1;
    end
    check("midreset no done", 32'(seen), 32'd0);
    run_op("after reset", 8'd120, 8'd30, 1'b0, 8'd150, 1'b1);

    // Random regression against a reference model
    for (int i = 0; i < 1000; i++) begin
      int ra, rb, ro, ex;
      ra = int'($urandom_range(250, 0));
      rb = int'($urandom_range(250, 0));
`ifdef FPADD_SUB_EN
      ro = int'($urandom_range(1, 0));
`else
      ro = 0;
`endif
      if (ro == 0) ex = (ra + rb) % P;
      else         ex = (ra >= rb) ? (ra - rb) : (ra - rb + P);
      run_op("random", W'(ra), W'(rb), ro[0], W'(ex), 1'b1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
